// File: rtl/lsu_stage.sv
// lsu_stage: memory-access pipeline stage between execute and writeback.
// Non-memory ops pass straight to a registered writeback pulse. Loads and
// stores go out on a valid/ready request bus, wait for a response (bounded by
// a timeout counter), and then produce the same kind of writeback pulse.
module lsu_stage #(
  parameter int XLEN    = 64,
  parameter int AW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // upstream instruction
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_wb_en,
  input  logic [3:0]        in_wb_sel,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_snpc,
  // data bus
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [AW-1:0]     bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_rdata,
  // writeback
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_en,
  output logic [XLEN-1:0]   wb_data,
  output logic              err_misalign,
  output logic              err_timeout
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // instruction fields held while the memory access is outstanding
  logic [4:0]      op_rd_q, op_rd_d;
  logic            op_wb_en_q, op_wb_en_d;
  logic [3:0]      op_sel_q, op_sel_d;
  logic [1:0]      op_size_q, op_size_d;
  logic            op_uns_q, op_uns_d;
  logic [OW-1:0]   op_off_q, op_off_d;
  logic [XLEN-1:0] op_alu_q, op_alu_d;
  logic [XLEN-1:0] op_imm_q, op_imm_d;
  logic [XLEN-1:0] op_snpc_q, op_snpc_d;

  // bus request registers, stable for the whole REQ phase
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]   bus_wstrb_q, bus_wstrb_d;

  // writeback registers
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_en_q, wb_en_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_misalign_q, err_misalign_d;
  logic            err_timeout_q, err_timeout_d;

  logic            accept;
  logic            in_mem;
  logic            in_misalign;
  logic [AW-1:0]   in_addr;
  logic [OW-1:0]   in_off;
  logic            resp_hit;
  logic            timeout_hit;
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_val;

  // One-hot writeback source select; anything not one-hot yields zero.
  function automatic logic [XLEN-1:0] select_wb(input logic [3:0] sel,
                                               input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] ld,
                                               input logic [XLEN-1:0] imm,
                                               input logic [XLEN-1:0] snpc);
    logic [XLEN-1:0] res;
    case (sel)
      4'b1000: res = alu;
      4'b0100: res = ld;
      4'b0010: res = imm;
      4'b0001: res = snpc;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Truncate to 8<<size bits and sign/zero-extend by shifting the field to
  // the top of the word and back down; doubleword always passes unchanged.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [XLEN-1:0] up;
    logic [XLEN-1:0] res;
    int              sh;
    sh = XLEN - (8 << size);
    up = raw << sh;
    if (uns && (size != 2'd3)) begin
      res = up >> sh;
    end else begin
      res = $unsigned($signed(up) >>> sh);
    end
    return res;
  endfunction

  // Byte-strobe pattern of an access before it is shifted to its lane.
  function automatic logic [NB-1:0] strb_base(input logic [1:0] size);
    logic [NB-1:0] res;
    case (size)
      2'd0:    res = NB'(1);
      2'd1:    res = NB'(3);
      2'd2:    res = NB'(15);
      default: res = NB'(255);
    endcase
    return res;
  endfunction

  assign accept      = in_valid && (state_q == IDLE);
  assign in_mem      = in_load || in_store;
  assign in_addr     = AW'(in_alu);
  assign in_off      = in_addr[OW-1:0];
  assign resp_hit    = (state_q == WAIT) && bus_resp_valid;
  // The abort decision is taken in the last allowed WAIT cycle, so the error
  // pulse appears exactly TIMEOUT cycles after WAIT was entered.
  assign timeout_hit = (state_q == WAIT) && !bus_resp_valid &&
                       (cnt_q == CW'(TIMEOUT - 1));
  assign load_raw    = bus_rdata >> {op_off_q, 3'b000};
  assign load_val    = extend_load(load_raw, op_size_q, op_uns_q);

  // Access is illegal when the address is not a multiple of its size, or a
  // doubleword is requested on a 32-bit datapath.
  always_comb begin
    in_misalign = 1'b0;
    case (in_size)
      2'd0:    in_misalign = 1'b0;
      2'd1:    in_misalign = in_addr[0];
      2'd2:    in_misalign = (in_addr[1:0] != 2'b00);
      default: in_misalign = (XLEN == 32) || (in_addr[2:0] != 3'b000);
    endcase
  end

  // State register and WAIT-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: legal memory ops go to REQ, handshake moves to WAIT,
  // a response or timeout returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && in_mem && !in_misalign) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (resp_hit || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: capture the instruction, build the bus request and form
  // the next writeback pulse.
  always_comb begin
    op_rd_d        = op_rd_q;
    op_wb_en_d     = op_wb_en_q;
    op_sel_d       = op_sel_q;
    op_size_d      = op_size_q;
    op_uns_d       = op_uns_q;
    op_off_d       = op_off_q;
    op_alu_d       = op_alu_q;
    op_imm_d       = op_imm_q;
    op_snpc_d      = op_snpc_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_wstrb_d    = bus_wstrb_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_en_d        = 1'b0;
    wb_data_d      = wb_data_q;
    err_misalign_d = 1'b0;
    err_timeout_d  = 1'b0;

    if (accept) begin
      op_rd_d    = in_rd;
      op_wb_en_d = in_wb_en;
      op_sel_d   = in_wb_sel;
      op_size_d  = in_size;
      op_uns_d   = in_unsigned;
      op_off_d   = in_off;
      op_alu_d   = in_alu;
      op_imm_d   = in_imm;
      op_snpc_d  = in_snpc;
      if (!in_mem) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = in_rd;
        wb_en_d    = in_wb_en;
        wb_data_d  = select_wb(in_wb_sel, in_alu, '0, in_imm, in_snpc);
      end else if (in_misalign) begin
        wb_valid_d     = 1'b1;
        wb_rd_d        = in_rd;
        wb_data_d      = '0;
        err_misalign_d = 1'b1;
      end else begin
        bus_we_d    = in_store;
        bus_addr_d  = {in_addr[AW-1:OW], {OW{1'b0}}};
        bus_wdata_d = in_wdata << {in_off, 3'b000};
        bus_wstrb_d = in_store ? (strb_base(in_size) << in_off) : '0;
      end
    end

    if (resp_hit) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = op_rd_q;
      wb_en_d    = op_wb_en_q;
      wb_data_d  = select_wb(op_sel_q, op_alu_q, load_val, op_imm_q, op_snpc_q);
    end else if (timeout_hit) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = op_rd_q;
      wb_data_d     = '0;
      err_timeout_d = 1'b1;
    end
  end

  // Datapath registers: captured fields, bus request and writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rd_q        <= '0;
      op_wb_en_q     <= 1'b0;
      op_sel_q       <= '0;
      op_size_q      <= '0;
      op_uns_q       <= 1'b0;
      op_off_q       <= '0;
      op_alu_q       <= '0;
      op_imm_q       <= '0;
      op_snpc_q      <= '0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_wstrb_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_en_q        <= 1'b0;
      wb_data_q      <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      op_rd_q        <= op_rd_d;
      op_wb_en_q     <= op_wb_en_d;
      op_sel_q       <= op_sel_d;
      op_size_q      <= op_size_d;
      op_uns_q       <= op_uns_d;
      op_off_q       <= op_off_d;
      op_alu_q       <= op_alu_d;
      op_imm_q       <= op_imm_d;
      op_snpc_q      <= op_snpc_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_wstrb_q    <= bus_wstrb_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_en_q        <= wb_en_d;
      wb_data_q      <= wb_data_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_en         = wb_en_q;
  assign wb_data       = wb_data_q;
  assign err_misalign  = err_misalign_q;
  assign err_timeout   = err_timeout_q;

endmodule
